adc_depth_sampler: RTL and testbench
====================================

Name: adc_depth_sampler

Overview:
- SPI master for the on-board 8-channel, 12-bit serial ADC (ADC128S022-style frame) that carries the analog pressure/depth transducer.
- Continuously converts one fixed channel, optionally averages, and presents a 32-bit zero-extended raw_depth word plus a one-cycle valid strobe.
- Sits directly upstream of the IMU Avalon slave, which latches raw_depth into its depth read register (addr 3).

Parameters:
- CLK_DIV, 25, clk cycles per SCLK half-period (50 MHz clk -> 1 MHz SCLK); legal range >= 2.
- CHANNEL, 0, ADC input channel for depth, 0..7.
- IDLE_CYCLES, 50, clk cycles with CS_N high between frames; legal range >= 1.
- AVG_LOG2, 4, log2 of the number of samples averaged; only used when the optional feature is compiled in.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run conversions while high.
- ADC_SDAT  in  1  ADC DOUT.
- ADC_CS_N  out  1  ADC chip select, active low.
- ADC_SADDR  out  1  ADC DIN (channel address).
- ADC_SCLK  out  1  ADC serial clock; idles high.
- raw_depth  out  32  latest depth result, bits [11:0] data, [31:12] zero.
- depth_valid  out  1  one-clk pulse when raw_depth is updated.

Behaviour:
- Reset values:
  - ADC_CS_N=1, ADC_SCLK=1, ADC_SADDR=0.
  - raw_depth=0, depth_valid=0.
  - Accumulator and sample counter = 0; discard flag = 1.
  - FSM = IDLE, gap counter = 0.
- Reset asserted mid-frame aborts the frame on the next clk edge with the reset values above; the partial sample is lost.
- FSM states:
  - IDLE: CS_N high; counts IDLE_CYCLES. On expiry, goes to FRAME if enable=1, otherwise stays in IDLE (counter saturates).
  - FRAME: CS_N low; generates 16 SCLK periods, each CLK_DIV clk low then CLK_DIV clk high. The first half-period after CS_N falls is high. After the 16th rising edge, holds SCLK high for one more half-period, then goes to DONE.
  - DONE: one clk. CS_N high, result processed, then IDLE with the gap counter cleared.
- Frame bit index k = 0..15, advanced per SCLK period.
- ADC_SADDR changes on the falling SCLK edge of bit k:
  - k=2: CHANNEL[2].
  - k=3: CHANNEL[1].
  - k=4: CHANNEL[0].
  - all other k: 0.
- ADC_SDAT is sampled on the clk where SCLK rises for bit k. Bits k=4..15 shift into a 12-bit register, MSB first; k=0..3 are ignored.
- Frame timing: one frame = IDLE_CYCLES + 32*CLK_DIV + CLK_DIV + 1 clk. With defaults that is 876 clk.
- The address sent in frame N selects the channel converted in frame N+1.
  - The first completed frame after reset is discarded (clear the discard flag, no output).
  - enable going low never sets the discard flag.
- enable deasserted during FRAME: the current frame completes normally, then the FSM idles.
- Output in DONE without averaging: raw_depth <= {20'b0, sample}; depth_valid=1 for exactly one clk.
- raw_depth holds its value between updates; depth_valid is 0 at all other times.

Optional Feature:
- ADC_DEPTH_AVG_EN defined:
  - Each accepted sample adds into a (12+AVG_LOG2)-bit accumulator; the counter increments.
  - When the counter reaches 2^AVG_LOG2: raw_depth <= zero-extended (accumulator >> AVG_LOG2), truncating; depth_valid pulses; accumulator and counter clear in the same clk.
  - Overflow is impossible by construction.
- ADC_DEPTH_AVG_EN undefined: every accepted sample is output directly. The accumulator, counter and AVG_LOG2 are unused and generate no logic.

Decomposition:
- Package adc_pkg holds:
  - FRAME_BITS=16, DATA_BITS=12, ADDR_FIRST_BIT=2, DATA_FIRST_BIT=4.
  - FSM state enum {IDLE, FRAME, DONE}.
  - Raw result width of 32.
- One sub-module, adc_sclk_gen:
  - Half-period counter driving ADC_SCLK.
  - Emits single-clk sclk_rise / sclk_fall strobes and the bit index.
  - Enabled only in FRAME.

Test Plan:
- Frame format: reset, enable=1, CHANNEL=5, CLK_DIV=2. Check CS_N low for exactly 16 SCLK periods plus trailing half-period; SADDR=1,0,1 on bits 2-4 and 0 elsewhere; SCLK idles high.
- Data capture: ADC model returns 12'hA5C on frames 2+. First frame produces no depth_valid; second frame gives depth_valid pulse with raw_depth=32'h00000A5C.
- Averaging, ADC_DEPTH_AVG_EN, AVG_LOG2=2: samples 100, 101, 102, 104 -> one depth_valid after the 4th accepted frame, raw_depth=101. No pulses on the first three.
- Enable drop: deassert enable at bit 7. Frame completes, result updates, CS_N stays high afterward. Re-enable -> next frame's result is output (no discard).
- Reset mid-frame at bit 9: next clk CS_N=1, SCLK=1, raw_depth=0. The first frame after release is discarded.
- Gap/throughput: defaults, macro off. depth_valid pulses every 876 clk in steady state; CS_N high for >= IDLE_CYCLES between frames.

Source files
------------

// File: rtl/adc_pkg.sv
// Purpose: shared constants, FSM state type and address-bit helper for the depth ADC sampler.
// Latency: none (declarations only).
// Backpressure: none.
package adc_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int RAW_W      = 32;
    localparam int BIT_W      = 4;

    localparam logic [BIT_W-1:0] ADDR_FIRST_BIT = 4'd2;
    localparam logic [BIT_W-1:0] DATA_FIRST_BIT = 4'd4;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        DONE
    } state_t;

    // DIN value for frame bit k: channel address MSB first on bits 2..4, zero elsewhere.
    function automatic logic addr_bit(input logic [2:0] ch, input logic [BIT_W-1:0] k);
        logic b;
        b = 1'b0;
        if (k == ADDR_FIRST_BIT) begin
            b = ch[2];
        end else if (k == ADDR_FIRST_BIT + 4'd1) begin
            b = ch[1];
        end else if (k == ADDR_FIRST_BIT + 4'd2) begin
            b = ch[0];
        end
        return b;
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Purpose: SCLK half-period generator for one 16-bit frame, with rise/fall strobes and bit index.
// Latency: strobes are combinational, asserted the clk before the SCLK edge they announce.
// Backpressure: none; held in reset (SCLK high) whenever en is low.
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             sclk,
    output logic             sclk_rise,
    output logic             sclk_fall,
    output logic [BIT_W-1:0] bit_idx,
    output logic             frame_end
);

    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int HALF_W = $clog2(2 * FRAME_BITS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FRAME_BITS);

    // Half-period 0 is the leading high half; odd halves are low, even halves high.
    // The final even half (HALF_LAST) is the trailing high hold after the 16th rise.
    logic [CNT_W-1:0]  cnt_q;
    logic [HALF_W-1:0] half_q;
    logic              half_end;

    assign half_end  = en && (cnt_q == CNT_LAST);
    assign sclk_fall = half_end && !half_q[0] && (half_q != HALF_LAST);
    assign sclk_rise = half_end && half_q[0];
    assign frame_end = half_end && (half_q == HALF_LAST);
    assign bit_idx   = half_q[BIT_W:1];

    // Half-period counter and SCLK register; idle state is SCLK high.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt_q  <= '0;
            half_q <= '0;
            sclk   <= 1'b1;
        end else if (half_end) begin
            cnt_q  <= '0;
            half_q <= half_q + HALF_W'(1);
            if (sclk_fall) begin
                sclk <= 1'b0;
            end else if (sclk_rise) begin
                sclk <= 1'b1;
            end
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adc_depth_sampler.sv
// Purpose: SPI master polling one ADC128S022 channel; emits a zero-extended 12-bit depth word (ADC_DEPTH_AVG_EN adds averaging).
// Latency: depth_valid fires 1 clk after the frame's DONE state; one frame = IDLE_CYCLES + 33*CLK_DIV + 1 clk.
// Backpressure: none; results are overwritten each update and the consumer must take the one-clk strobe.
module adc_depth_sampler
    import adc_pkg::*;
#(
    parameter int CLK_DIV     = 25,
    parameter int CHANNEL     = 0,
    parameter int IDLE_CYCLES = 50,
    parameter int AVG_LOG2    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             ADC_SDAT,
    output logic             ADC_CS_N,
    output logic             ADC_SADDR,
    output logic             ADC_SCLK,
    output logic [RAW_W-1:0] raw_depth,
    output logic             depth_valid
);

    // Elaboration-time guard against illegal parameter values.
    if (CLK_DIV < 2 || IDLE_CYCLES < 1 || CHANNEL < 0 || CHANNEL > 7 ||
        AVG_LOG2 < 0 || AVG_LOG2 > 16) begin : g_bad_params
        $error("adc_depth_sampler: illegal parameter value");
    end

    localparam int GAP_W = $clog2(IDLE_CYCLES) + 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_CYCLES - 1);
    localparam logic [2:0]       CH       = 3'(CHANNEL);

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               sclk_rise, sclk_fall, frame_end;
    logic [BIT_W-1:0]   bit_idx;
    logic [DATA_BITS-1:0] shift_q;
    logic               discard_q;

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (state_q == FRAME),
        .sclk      (ADC_SCLK),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .bit_idx   (bit_idx),
        .frame_end (frame_end)
    );

    assign ADC_CS_N = (state_q != FRAME);

    // FSM state and inter-frame gap counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state: gap counter saturates in IDLE until enable allows the next frame.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (gap_q == GAP_LAST) begin
                    if (enable) begin
                        state_d = FRAME;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            FRAME: begin
                if (frame_end) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                gap_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gap_d   = '0;
            end
        endcase
    end

`ifdef ADC_DEPTH_AVG_EN
    localparam int ACC_W = DATA_BITS + AVG_LOG2;
    localparam logic [AVG_LOG2:0] CNT_LAST = (AVG_LOG2 + 1)'((2 ** AVG_LOG2) - 1);

    logic [ACC_W-1:0]  acc_q;
    logic [AVG_LOG2:0] cnt_q;
    logic [ACC_W-1:0]  acc_sum;

    // 2^AVG_LOG2 samples of 12 bits always fit in ACC_W bits, so no overflow handling is needed.
    assign acc_sum = acc_q + ACC_W'(shift_q);
`endif

    // Serial datapath: DIN on falling edges, DOUT capture on rising edges, result handling in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            ADC_SADDR   <= 1'b0;
            shift_q     <= '0;
            discard_q   <= 1'b1;
            raw_depth   <= '0;
            depth_valid <= 1'b0;
`ifdef ADC_DEPTH_AVG_EN
            acc_q       <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            depth_valid <= 1'b0;
            if (sclk_fall) begin
                ADC_SADDR <= addr_bit(CH, bit_idx);
            end
            if (sclk_rise && (bit_idx >= DATA_FIRST_BIT)) begin
                shift_q <= {shift_q[DATA_BITS-2:0], ADC_SDAT};
            end
            if (state_q == DONE) begin
                // The first frame's data belongs to whatever channel the ADC powered up on.
                if (discard_q) begin
                    discard_q <= 1'b0;
                end else begin
`ifdef ADC_DEPTH_AVG_EN
                    if (cnt_q == CNT_LAST) begin
                        raw_depth   <= {{(RAW_W - DATA_BITS){1'b0}}, acc_sum[ACC_W-1:AVG_LOG2]};
                        depth_valid <= 1'b1;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                    end else begin
                        acc_q <= acc_sum;
                        cnt_q <= cnt_q + (AVG_LOG2 + 1)'(1);
                    end
`else
                    raw_depth   <= {{(RAW_W - DATA_BITS){1'b0}}, shift_q};
                    depth_valid <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_depth_sampler.sv
// Purpose: self-checking bench for adc_depth_sampler with a behavioural ADC and result model.
// Latency: checks frame timing, data path, discard rule, enable drop, mid-frame reset and throughput.
// Backpressure: n/a.
module tb_adc_depth_sampler;

    localparam int CLK_DIV     = 2;
    localparam int CHANNEL     = 5;
    localparam int IDLE_CYCLES = 5;
    localparam int AVG_LOG2    = 2;
    localparam int PERIOD      = IDLE_CYCLES + 33 * CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        ADC_SDAT = 1'b0;
    logic        ADC_CS_N;
    logic        ADC_SADDR;
    logic        ADC_SCLK;
    logic [31:0] raw_depth;
    logic        depth_valid;

    always #5 clk = ~clk;

    adc_depth_sampler #(
        .CLK_DIV     (CLK_DIV),
        .CHANNEL     (CHANNEL),
        .IDLE_CYCLES (IDLE_CYCLES),
        .AVG_LOG2    (AVG_LOG2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .ADC_SDAT    (ADC_SDAT),
        .ADC_CS_N    (ADC_CS_N),
        .ADC_SADDR   (ADC_SADDR),
        .ADC_SCLK    (ADC_SCLK),
        .raw_depth   (raw_depth),
        .depth_valid (depth_valid)
    );

    int errors = 0;
    int checks = 0;

    // ADC / result model state
    int          cyc = 0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_valid = 1'b0;
    bit          in_frame = 0, discard = 1, gap_valid = 0;
    int          rises = 0, falls = 0, low_cnt = 0;
    int          frames_done = 0, frame_starts = 0;
    logic [15:0] addr_bits = '0, last_addr = '0;
    logic [11:0] frame_val = '0;
    int          last_low = 0, last_rises = 0, last_falls = 0;
    int          cs_high_run = 0, min_gap = 1000000;
    int          sclk_idle_err = 0, valid_long = 0;
    int          avg_sum;
    logic [31:0] exp_q[$], got_q[$];
    logic [11:0] forced_q[$];
    int          avg_buf[$];
    int          valid_cyc[$];

    // Behavioural ADC: shifts DOUT on SCLK falls, samples DIN on rises, and predicts outputs.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            in_frame  = 0;
            discard   = 1;
            gap_valid = 0;
            avg_buf.delete();
            ADC_SDAT  = 1'b0;
        end else begin
            if (prev_cs === 1'b1 && ADC_CS_N === 1'b0) begin
                in_frame = 1;
                frame_starts++;
                rises = 0;
                falls = 0;
                low_cnt = 0;
                addr_bits = '0;
                if (forced_q.size() > 0) frame_val = forced_q.pop_front();
                else frame_val = 12'($urandom_range(0, 4095));
                ADC_SDAT = 1'b0;
                if (gap_valid && cs_high_run < min_gap) min_gap = cs_high_run;
            end
            if (ADC_CS_N === 1'b0 && in_frame) begin
                low_cnt++;
                if (prev_sclk === 1'b1 && ADC_SCLK === 1'b0) begin
                    ADC_SDAT = (falls >= 4 && falls < 16) ? frame_val[15 - falls] : 1'b0;
                    falls++;
                end
                if (prev_sclk === 1'b0 && ADC_SCLK === 1'b1) begin
                    if (rises < 16) addr_bits[rises] = ADC_SADDR;
                    rises++;
                end
            end
            if (prev_cs === 1'b0 && ADC_CS_N === 1'b1 && in_frame) begin
                in_frame   = 0;
                last_low   = low_cnt;
                last_rises = rises;
                last_falls = falls;
                last_addr  = addr_bits;
                if (rises == 16) begin
                    frames_done++;
                    gap_valid = 1;
                    if (discard) begin
                        discard = 0;
                    end else begin
`ifdef ADC_DEPTH_AVG_EN
                        avg_buf.push_back(int'(frame_val));
                        if (avg_buf.size() == (1 << AVG_LOG2)) begin
                            avg_sum = 0;
                            foreach (avg_buf[i]) avg_sum += avg_buf[i];
                            exp_q.push_back(32'(avg_sum >> AVG_LOG2));
                            avg_buf.delete();
                        end
`else
                        exp_q.push_back({20'b0, frame_val});
`endif
                    end
                end
            end
            if (ADC_CS_N === 1'b1) begin
                if (ADC_SCLK !== 1'b1) sclk_idle_err++;
                cs_high_run++;
            end else begin
                cs_high_run = 0;
            end
            if (depth_valid === 1'b1) begin
                got_q.push_back(raw_depth);
                valid_cyc.push_back(cyc);
                if (prev_valid === 1'b1) valid_long++;
            end
        end
        prev_cs    = ADC_CS_N;
        prev_sclk  = ADC_SCLK;
        prev_valid = depth_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frames(input int n, output bit ok);
        int target;
        int budget;
        target = frames_done + n;
        budget = n * PERIOD * 2 + 50;
        while (frames_done < target && budget > 0) begin
            tick(1);
            budget--;
        end
        tick(3);
        ok = (frames_done >= target);
    endtask

    task automatic wait_falls(input int n, output bit ok);
        int budget;
        budget = 3 * PERIOD;
        while (!(in_frame && falls == n) && budget > 0) begin
            tick(1);
            budget--;
        end
        ok = (in_frame && falls == n);
    endtask

    task automatic test_reset;
        int starts;
        reset  = 1'b1;
        enable = 1'b0;
        tick(3);
        checks++; if (ADC_CS_N !== 1'b1) begin errors++; $display("FAIL reset_cs_n got=%b exp=1", ADC_CS_N); end
        checks++; if (ADC_SCLK !== 1'b1) begin errors++; $display("FAIL reset_sclk got=%b exp=1", ADC_SCLK); end
        checks++; if (ADC_SADDR !== 1'b0) begin errors++; $display("FAIL reset_saddr got=%b exp=0", ADC_SADDR); end
        checks++; if (raw_depth !== 32'h0) begin errors++; $display("FAIL reset_raw got=%h exp=0", raw_depth); end
        checks++; if (depth_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", depth_valid); end
        exp_q.delete();
        got_q.delete();
        reset  = 1'b0;
        starts = frame_starts;
        tick(3 * PERIOD);
        checks++; if (frame_starts != starts) begin errors++; $display("FAIL idle_disabled frames got=%0d exp=%0d", frame_starts, starts); end
    endtask

    task automatic test_frame_format;
        bit          ok;
        logic [2:0]  ch;
        logic [15:0] exp_addr;
        ch = 3'(CHANNEL);
        exp_addr = '0;
        exp_addr[2] = ch[2];
        exp_addr[3] = ch[1];
        exp_addr[4] = ch[0];
        enable = 1'b1;
        wait_frames(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame_timeout got=%0d exp=1", frames_done); end
        checks++; if (last_low != 33 * CLK_DIV) begin errors++; $display("FAIL cs_low_len got=%0d exp=%0d", last_low, 33 * CLK_DIV); end
        checks++; if (last_rises != 16) begin errors++; $display("FAIL sclk_rises got=%0d exp=16", last_rises); end
        checks++; if (last_falls != 16) begin errors++; $display("FAIL sclk_falls got=%0d exp=16", last_falls); end
        checks++; if (last_addr !== exp_addr) begin errors++; $display("FAIL saddr_bits got=%h exp=%h", last_addr, exp_addr); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL first_discard pulses got=%0d exp=0", got_q.size()); end
    endtask

    task automatic test_data_capture;
        bit ok;
        forced_q.push_back(12'hA5C);
        wait_frames(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL capture_timeout got=%0d exp=1", frames_done); end
`ifndef ADC_DEPTH_AVG_EN
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL capture_pulses got=%0d exp=1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 32'h00000A5C) begin errors++; $display("FAIL capture_a5c got=%h exp=00000a5c", got_q[0]); end
        end
`endif
        wait_frames(6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL random_timeout got=%0d exp=ok", frames_done); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL capture_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL capture_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_enable_drop;
        bit ok;
        int starts;
        wait_falls(8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bit7_timeout got=%0d exp=8", falls); end
        enable = 1'b0;
        wait_frames(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_complete got=%0d exp=done", frames_done); end
        starts = frame_starts;
        tick(3 * PERIOD);
        checks++; if (frame_starts != starts) begin errors++; $display("FAIL drop_idle frames got=%0d exp=%0d", frame_starts, starts); end
        checks++; if (ADC_CS_N !== 1'b1) begin errors++; $display("FAIL drop_cs_n got=%b exp=1", ADC_CS_N); end
`ifndef ADC_DEPTH_AVG_EN
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL drop_result got=%0d exp=1", got_q.size()); end
`endif
        enable = 1'b1;
        wait_frames(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL reenable_timeout got=%0d exp=done", frames_done); end
`ifndef ADC_DEPTH_AVG_EN
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL reenable_no_discard got=%0d exp=2", got_q.size()); end
`endif
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL drop_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL drop_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        wait_falls(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bit9_timeout got=%0d exp=10", falls); end
        reset = 1'b1;
        tick(1);
        checks++; if (ADC_CS_N !== 1'b1) begin errors++; $display("FAIL midreset_cs_n got=%b exp=1", ADC_CS_N); end
        checks++; if (ADC_SCLK !== 1'b1) begin errors++; $display("FAIL midreset_sclk got=%b exp=1", ADC_SCLK); end
        checks++; if (raw_depth !== 32'h0) begin errors++; $display("FAIL midreset_raw got=%h exp=0", raw_depth); end
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        wait_frames(1, ok);
        checks++; if (!ok || got_q.size() != 0) begin errors++; $display("FAIL midreset_discard pulses got=%0d exp=0", got_q.size()); end
        wait_frames(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midreset_timeout got=%0d exp=done", frames_done); end
`ifndef ADC_DEPTH_AVG_EN
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL midreset_result got=%0d exp=1", got_q.size()); end
`endif
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL midreset_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midreset_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_throughput;
        bit ok;
        valid_cyc.delete();
        min_gap = 1000000;
        wait_frames(6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tput_timeout got=%0d exp=done", frames_done); end
`ifndef ADC_DEPTH_AVG_EN
        checks++; if (valid_cyc.size() < 5) begin errors++; $display("FAIL tput_pulses got=%0d exp>=5", valid_cyc.size()); end
        for (int i = 1; i < valid_cyc.size(); i++) begin
            checks++;
            if (valid_cyc[i] - valid_cyc[i-1] != PERIOD) begin
                errors++; $display("FAIL tput_interval[%0d] got=%0d exp=%0d", i, valid_cyc[i] - valid_cyc[i-1], PERIOD);
            end
        end
`endif
        checks++; if (min_gap < IDLE_CYCLES) begin errors++; $display("FAIL cs_gap got=%0d exp>=%0d", min_gap, IDLE_CYCLES); end
        checks++; if (valid_long != 0) begin errors++; $display("FAIL valid_width long_pulses got=%0d exp=0", valid_long); end
        checks++; if (sclk_idle_err != 0) begin errors++; $display("FAIL sclk_idle low_while_cs_high got=%0d exp=0", sclk_idle_err); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL tput_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL tput_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

`ifdef ADC_DEPTH_AVG_EN
    task automatic test_average;
        bit ok;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        forced_q.delete();
        forced_q.push_back(12'd0);
        forced_q.push_back(12'd100);
        forced_q.push_back(12'd101);
        forced_q.push_back(12'd102);
        forced_q.push_back(12'd104);
        wait_frames(4, ok);
        checks++; if (!ok || got_q.size() != 0) begin errors++; $display("FAIL avg_early pulses got=%0d exp=0", got_q.size()); end
        wait_frames(1, ok);
        checks++; if (!ok || got_q.size() != 1) begin errors++; $display("FAIL avg_pulses got=%0d exp=1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 32'd101) begin errors++; $display("FAIL avg_value got=%0d exp=101", got_q[0]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask
`endif

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        test_reset();
        test_frame_format();
        test_data_capture();
        test_enable_drop();
        test_reset_mid_frame();
        test_throughput();
`ifdef ADC_DEPTH_AVG_EN
        test_average();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
